opr_sequencer: RTL

- Fetch/decode/issue controller that drives the operand demultiplexer (OPR_sel plus operand) feeding the WTR, INC, RESET and WTA execution units.
- Reads a byte-wide instruction stream from program memory and presents each operand to the demux with a safe setup ordering.
- Holds the operation until the selected unit acknowledges, then returns the select lines to idle.
- Sits between program memory and the demux/execution units in the CCSS processor control path.

---
 rtl/opr_sequencer_pkg.sv | 34 +++
 rtl/opr_sequencer_if.sv | 26 ++
 rtl/opr_sequencer_timeout_counter.sv | 29 ++
 rtl/opr_sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/opr_sequencer_pkg.sv
// Shared opcode, demux-select and FSM state encodings for the operand sequencer.
// The SEL_* codes are also used by the demux, so they must not be renumbered.
package opr_sequencer_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_RESET = 3'b001;
  localparam logic [2:0] OP_WTA   = 3'b010;
  localparam logic [2:0] OP_WTR   = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_RESET = 3'b001;
  localparam logic [2:0] SEL_WTA   = 3'b010;
  localparam logic [2:0] SEL_WTR   = 3'b011;
  localparam logic [2:0] SEL_INC   = 3'b100;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH_OP  = 4'd1;
  localparam logic [3:0] ST_LATCH_OP  = 4'd2;
  localparam logic [3:0] ST_FETCH_ARG = 4'd3;
  localparam logic [3:0] ST_LATCH_ARG = 4'd4;
  localparam logic [3:0] ST_ISSUE     = 4'd5;
  localparam logic [3:0] ST_WAIT_DONE = 4'd6;
  localparam logic [3:0] ST_GAP       = 4'd7;
  localparam logic [3:0] ST_HALT      = 4'd8;
  localparam logic [3:0] ST_ERROR     = 4'd9;

  // Opcodes 001..100 carry one operand byte; the select code equals the opcode.
  function automatic logic has_operand(input logic [2:0] op);
    return (op == OP_RESET) || (op == OP_WTA) || (op == OP_WTR) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/opr_sequencer_if.sv
// Program-memory read port and demux/execution-unit issue port of the sequencer.
interface opr_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [2:0]        OPR_sel;
  logic [DATA_W-1:0] operand;
  logic              exec_valid;
  logic              exec_done;

  // imem_rdata is the byte at the imem_addr of the previous cycle. exec_valid rises
  // together with a nonzero OPR_sel and holds, with OPR_sel and operand stable, until
  // the unit raises exec_done; exec_done counts only while exec_valid is high, and
  // the cycle after it is accepted exec_valid and OPR_sel drop back to 0.
  modport master (
    output imem_addr, OPR_sel, operand, exec_valid,
    input  imem_rdata, exec_done
  );

  modport slave (
    input  imem_addr, OPR_sel, operand, exec_valid,
    output imem_rdata, exec_done
  );
endinterface

// File: rtl/opr_sequencer_timeout_counter.sv
// Wait-cycle counter for an issued operation; expired marks the last allowed cycle.
module opr_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/opr_sequencer.sv
// Fetch/decode/issue controller driving the operand demux for the RESET/WTA/WTR/INC units.
module opr_sequencer
  import opr_sequencer_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  opr_sequencer_if.master   bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [3:0]        dbg_state
);

  logic [3:0]        state;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        opcode_q;
  logic [2:0]        sel_q;
  logic [2:0]        fetched_op;
  logic [DATA_W-1:0] operand_q;
  logic              valid_q;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              cnt_expired;

  assign fetched_op = bus.imem_rdata[2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      opcode_q  <= OP_NOP;
      operand_q <= '0;
      sel_q     <= SEL_NONE;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT, ST_ERROR: begin
          if (start) begin
            pc_q  <= '0;
            state <= ST_FETCH_OP;
          end
        end
        ST_FETCH_OP:  state <= ST_LATCH_OP;
        ST_LATCH_OP: begin
          opcode_q <= fetched_op;
          pc_q     <= pc_q + ADDR_W'(1);
          if (fetched_op == OP_NOP)        state <= ST_FETCH_OP;
          else if (fetched_op == OP_HALT)  state <= ST_HALT;
          else if (has_operand(fetched_op)) state <= ST_FETCH_ARG;
          else                             state <= ST_ERROR;
        end
        ST_FETCH_ARG: state <= ST_LATCH_ARG;
        // operand lands here, a full cycle before OPR_sel leaves 000 at the end of ISSUE
        ST_LATCH_ARG: begin
          operand_q <= bus.imem_rdata;
          pc_q      <= pc_q + ADDR_W'(1);
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          sel_q   <= opcode_q;
          valid_q <= 1'b1;
          state   <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.exec_done) begin
            sel_q   <= SEL_NONE;
            valid_q <= 1'b0;
            state   <= ST_GAP;
          end else if (cnt_expired) begin
            sel_q   <= SEL_NONE;
            valid_q <= 1'b0;
            state   <= ST_ERROR;
          end
        end
        ST_GAP:       state <= ST_FETCH_OP;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  assign cnt_clear  = (state == ST_ISSUE);
  assign cnt_enable = (state == ST_WAIT_DONE) && !bus.exec_done;

  opr_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // imem_addr tracks pc so the address is already presented during FETCH_OP/FETCH_ARG
  assign bus.imem_addr  = pc_q;
  assign bus.OPR_sel    = sel_q;
  assign bus.operand    = operand_q;
  assign bus.exec_valid = valid_q;

  assign pc        = pc_q;
  assign halted    = (state == ST_HALT);
  assign error     = (state == ST_ERROR);
  assign busy      = !((state == ST_IDLE) || (state == ST_HALT) || (state == ST_ERROR));
  assign dbg_state = state;

endmodule
